// File: rtl/arb_resp_demux_if.sv
// ---------------------------------------------------------------------------
// arb_resp_demux_if
//   Slave-side request/response bus of the arbiter response demux.
//   Signal suffixes are from the point of view of the demux (the master):
//     slv_req_o        request valid towards the slave
//     slv_gnt_i        slave accepts the request
//     slv_rsp_valid_i  slave response valid (responses come back in order)
//     slv_rsp_data_i   slave response payload, DataWidth bits
//     slv_rsp_ready_o  demux accepts the response
//   Modports: master = demux side, slave = slave/memory side.
// ---------------------------------------------------------------------------
interface arb_resp_demux_if #(
  parameter int DataWidth = 32
);
  logic                 slv_req_o;
  logic                 slv_gnt_i;
  logic                 slv_rsp_valid_i;
  logic [DataWidth-1:0] slv_rsp_data_i;
  logic                 slv_rsp_ready_o;

  modport master (
    output slv_req_o,
    input  slv_gnt_i,
    input  slv_rsp_valid_i,
    input  slv_rsp_data_i,
    output slv_rsp_ready_o
  );

  modport slave (
    input  slv_req_o,
    output slv_gnt_i,
    output slv_rsp_valid_i,
    output slv_rsp_data_i,
    input  slv_rsp_ready_o
  );
endinterface

// File: rtl/arb_resp_demux.sv
// ---------------------------------------------------------------------------
// arb_resp_demux
//   Sits behind the round-robin arbitration tree. Forwards the arbitrated
//   request to one slave port, remembers the winning input index of each
//   accepted request in an in-order FIFO, and steers every in-order slave
//   response back to the input that issued it. The FIFO depth bounds the
//   number of outstanding transactions; when it is full the arbiter is
//   back-pressured.
//
//   Ports:
//     clk_i, rst_ni     clock (rising edge), synchronous active-low reset
//     flush_i           synchronous clear of the tracking FIFO
//     arb_req_i/idx_i   arbitrated request valid and winning input index
//     arb_gnt_o         grant back to the arbiter
//     slv               slave bus (arb_resp_demux_if.master)
//     rsp_valid_o       per-input response valid, one-hot or zero
//     rsp_data_o        response payload broadcast to all inputs
//     rsp_ready_i       per-input response ready
//     outstanding_o     current FIFO occupancy
//     err_o             sticky flag: response seen while nothing outstanding
//
//   Optional feature macro: ARB_RESP_DEMUX_ERR_EN builds the error detector;
//   without it err_o is tied low.
// ---------------------------------------------------------------------------
module arb_resp_demux #(
  parameter int NumIn          = 4,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4,
  localparam int IdxWidth      = $clog2(NumIn),
  localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 arb_req_i,
  input  logic [IdxWidth-1:0]  arb_idx_i,
  output logic                 arb_gnt_o,
  arb_resp_demux_if.master     slv,
  output logic [NumIn-1:0]     rsp_valid_o,
  output logic [DataWidth-1:0] rsp_data_o,
  input  logic [NumIn-1:0]     rsp_ready_i,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 err_o
);

  localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

  logic [IdxWidth-1:0] fifo_q [MaxOutstanding];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;

  logic                full, empty, push, pop;
  logic [IdxWidth-1:0] head;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // Request path. Full gates the push even if a pop happens this cycle, so
  // the grant never depends on the response handshake.
  assign slv.slv_req_o = arb_req_i & ~full;
  assign arb_gnt_o     = slv.slv_gnt_i & arb_req_i & ~full;
  assign push          = arb_gnt_o;

  // Response path: only the input at the FIFO head may see a valid.
  for (genvar gi = 0; gi < NumIn; gi++) begin : g_rsp_valid
    assign rsp_valid_o[gi] = slv.slv_rsp_valid_i & ~empty & (head == IdxWidth'(gi));
  end

  assign slv.slv_rsp_ready_o = ~empty & rsp_ready_i[head];
  assign rsp_data_o          = slv.slv_rsp_data_i;
  assign pop                 = slv.slv_rsp_valid_i & slv.slv_rsp_ready_o;

  // Next-state for pointers (wrap at MaxOutstanding-1) and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Index storage needs no reset: entries are only read while count_q > 0.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      fifo_q[wr_ptr_q] <= arb_idx_i;
    end
  end

  assign outstanding_o = count_q;

`ifdef ARB_RESP_DEMUX_ERR_EN
  logic err_q, err_d;

  // Sticky until reset; a flush in the same cycle masks the detection.
  assign err_d = err_q | (slv.slv_rsp_valid_i & empty & ~flush_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_arb_resp_demux.sv
// ---------------------------------------------------------------------------
// tb_arb_resp_demux
//   Self-checking bench for arb_resp_demux (NumIn=4, DataWidth=32,
//   MaxOutstanding=3 so that pointer wrap is exercised on a non-power-of-two
//   depth). A queue of outstanding indices models the design; a separate
//   monitor checks each routed response against a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_arb_resp_demux;
  localparam int NI   = 4;
  localparam int DW   = 32;
  localparam int MAXO = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          arb_req_i;
  logic [1:0]    arb_idx_i;
  logic          arb_gnt_o;
  logic [NI-1:0] rsp_valid_o;
  logic [DW-1:0] rsp_data_o;
  logic [NI-1:0] rsp_ready_i;
  logic [1:0]    outstanding_o;
  logic          err_o;

  arb_resp_demux_if #(.DataWidth(DW)) slv ();

  arb_resp_demux #(
    .NumIn(NI), .DataWidth(DW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .arb_req_i(arb_req_i), .arb_idx_i(arb_idx_i), .arb_gnt_o(arb_gnt_o),
    .slv(slv),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [NI-1:0] vld;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];     // scoreboard: responses the model says get accepted
  int   model_q[$];   // reference: input indices of outstanding requests
  bit   err_m;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check combinational outputs
  // against the model, then advance the model to the state after next edge.
  task automatic cyc(input bit req, input logic [1:0] idx, input bit gnt,
                     input bit rv, input logic [DW-1:0] data,
                     input logic [NI-1:0] rdy, input bit fl);
    bit            full_m, empty_m, push_m, pop_m, exp_rdy;
    logic [NI-1:0] exp_vld;
    @(posedge clk_i);
    #1;
    arb_req_i           = req;
    arb_idx_i           = idx;
    slv.slv_gnt_i       = gnt;
    slv.slv_rsp_valid_i = rv;
    slv.slv_rsp_data_i  = data;
    rsp_ready_i         = rdy;
    flush_i             = fl;
    #2;
    full_m  = (model_q.size() == MAXO);
    empty_m = (model_q.size() == 0);
    push_m  = req && gnt && !full_m;
    exp_rdy = !empty_m && rdy[model_q[0]];
    exp_vld = (rv && !empty_m) ? NI'(1 << model_q[0]) : '0;
    pop_m   = rv && exp_rdy;
    chk("slv_req_o", 64'(slv.slv_req_o), 64'(req && !full_m));
    chk("arb_gnt_o", 64'(arb_gnt_o), 64'(push_m));
    chk("slv_rsp_ready_o", 64'(slv.slv_rsp_ready_o), 64'(exp_rdy));
    chk("rsp_valid_o", 64'(rsp_valid_o), 64'(exp_vld));
    chk("rsp_data_o", 64'(rsp_data_o), 64'(data));
    chk("outstanding_o", 64'(outstanding_o), 64'(model_q.size()));
    chk("err_o", 64'(err_o), 64'(err_m));
    if (pop_m) exp_q.push_back('{vld: exp_vld, data: data});
`ifdef ARB_RESP_DEMUX_ERR_EN
    if (rv && empty_m && !fl) err_m = 1'b1;
`endif
    if (fl) begin
      model_q.delete();
    end else begin
      if (pop_m)  void'(model_q.pop_front());
      if (push_m) model_q.push_back(int'(idx));
    end
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 1'b0, 1'b0, $urandom, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    arb_req_i = 1'b0; arb_idx_i = '0; slv.slv_gnt_i = 1'b0;
    slv.slv_rsp_valid_i = 1'b0; slv.slv_rsp_data_i = '0;
    rsp_ready_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_q.delete();
    err_m = 1'b0;
  endtask

  // Monitor: every response handshake must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1 && slv.slv_rsp_valid_i && slv.slv_rsp_ready_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid_o), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_rsp_valid", 64'(rsp_valid_o), 64'(e.vld));
          chk("mon_rsp_data", 64'(rsp_data_o), 64'(e.data));
        end
      end
    end
  end

  initial begin
    bit            rv;
    logic [NI-1:0] rdy;
    err_m = 1'b0;
    rst_ni = 1'b0;
    do_reset();

    // Reset state with idle inputs.
    idle();

    // Basic round trip.
    cyc(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'hCAFE, 4'b0100, 1'b0);
    idle();

    // In-order routing.
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'hD000_0000, 4'hF, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'hD000_0001, 4'hF, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'hD000_0002, 4'hF, 1'b0);
    idle();

    // Full back-pressure, then same-cycle pop + request (no push), then accept.
    for (int i = 0; i < MAXO; i++) cyc(1'b1, 2'(i), 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 1'b1, 32'h1111, 4'hF, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < MAXO; i++) cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'h2000 + i, 4'hF, 1'b0);
    idle();

    // Head stall: head wants input 1, only input 0 ready.
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'h3333, 4'b0001, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'h3333, 4'b0010, 1'b0);
    idle();

    // Pointer wrap: keep one outstanding, 7 interleaved push/pop pairs.
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    for (int i = 1; i <= 7; i++) cyc(1'b1, 2'(i), 1'b1, 1'b1, 32'h4000 + i, 4'hF, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'h4FFF, 4'hF, 1'b0);
    idle();

    // Illegal response while empty, then flush with 2 entries.
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 32'hBAD0, 4'hF, 1'b0);
    idle();
    cyc(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
    idle();

    // Reset with entries outstanding discards them and clears the error.
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    do_reset();
    idle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rv  = (model_q.size() != 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
      rdy = NI'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
          rv, $urandom, rdy, ($urandom_range(0, 49) == 0));
    end
    // Drain everything that is still outstanding.
    for (int i = 0; i < 20; i++) cyc(1'b0, 2'd0, 1'b0, model_q.size() != 0, $urandom, 4'hF, 1'b0);
    idle();
    @(posedge clk_i);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_resp_demux.md
# arb_resp_demux

Response-routing stage directly downstream of the round-robin arbitration tree. It forwards the arbitrated request stream to a single slave port and records the winning input index of every accepted request in an in-order tracking FIFO. It then steers each in-order slave response back to the input that issued the matching request. The FIFO caps the number of outstanding transactions, and the block back-pressures the arbiter when the FIFO is full.

## Interface
Parameters:
- NumIn, 4: number of arbitrated inputs; ≥2.
- DataWidth, 32: response payload width in bits.
- MaxOutstanding, 4: tracking FIFO depth; ≥1, any value (not restricted to powers of two).
- IdxWidth, $clog2(NumIn): width of the input index; derived, not overridden.
- CntWidth, $clog2(MaxOutstanding+1): width of the occupancy count; derived.

Ports:
- clk_i  in  1  clock, rising edge. Single clock domain.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous clear of the tracking state.
- arb_req_i  in  1  request valid from the arbiter output.
- arb_idx_i  in  IdxWidth  winning input index from the arbiter.
- arb_gnt_o  out  1  grant returned to the arbiter.
- slv_req_o  out  1  request valid to the slave.
- slv_gnt_i  in  1  slave accepts the request.
- slv_rsp_valid_i  in  1  slave response valid; responses arrive in request order.
- slv_rsp_data_i  in  DataWidth  slave response payload.
- slv_rsp_ready_o  out  1  response accepted.
- rsp_valid_o  out  NumIn  per-input response valid; one-hot or zero.
- rsp_data_o  out  DataWidth  response payload, broadcast to all inputs.
- rsp_ready_i  in  NumIn  per-input response ready.
- outstanding_o  out  CntWidth  current FIFO occupancy.
- err_o  out  1  sticky protocol-error flag.

## Operation
- full = (count == MaxOutstanding); empty = (count == 0).
- Request path (combinational):
  - slv_req_o = arb_req_i & ~full.
  - arb_gnt_o = slv_gnt_i & arb_req_i & ~full.
- Push: when arb_req_i & slv_gnt_i & ~full, write arb_idx_i at wr_ptr and advance wr_ptr.
- Response path (combinational):
  - head = FIFO entry at rd_ptr.
  - rsp_valid_o[head] = slv_rsp_valid_i & ~empty; all other bits 0.
  - slv_rsp_ready_o = ~empty & rsp_ready_i[head].
  - rsp_data_o = slv_rsp_data_i, unregistered.
- Pop: when slv_rsp_valid_i & slv_rsp_ready_o, advance rd_ptr.
- Pointers wrap from MaxOutstanding-1 to 0.
- Count update: count += push − pop; a simultaneous push and pop leaves the count unchanged.
- Full blocks a push even when a pop occurs in the same cycle. There is no full-bypass, which keeps slv_gnt_i independent of the response path.
- While empty, slv_rsp_ready_o = 0 and no rsp_valid_o bit is set. A response arriving while empty is illegal (see Configuration).
- flush_i: pointers and count go to 0 next cycle. Flush takes priority over push and pop in the same cycle. Requests and responses are still routed combinationally during the flush cycle. err_o is not cleared by flush.

## Timing
- Reset (rst_ni=0 at a clock edge): wr_ptr = rd_ptr = count = 0, err_o = 0.
- After reset, with inputs idle:
  - slv_req_o = 0, arb_gnt_o = 0, slv_rsp_ready_o = 0.
  - rsp_valid_o = 0, outstanding_o = 0.
  - rsp_data_o follows slv_rsp_data_i.
- Request and response paths have zero latency (combinational).
- An accepted request is visible in outstanding_o one cycle later.
- The earliest routable response is one cycle after its request handshake. A response in the same cycle as its own request is not supported.
- Reset asserted mid-transaction discards all tracked indices. Any responses still in flight afterwards are illegal.

## Configuration
- ARB_RESP_DEMUX_ERR_EN defined:
  - err_o is a register, set on any cycle with slv_rsp_valid_i & empty & ~flush_i.
  - err_o stays set until reset.
- ARB_RESP_DEMUX_ERR_EN undefined:
  - err_o is tied to 0 and the detection logic is not built.
  - The illegal response is still not accepted (slv_rsp_ready_o = 0).

## Test plan
- Basic round trip: NumIn=4. Arbiter presents idx 2 with slv_gnt_i=1 → arb_gnt_o=1 and outstanding_o=1 next cycle. Response 0xCAFE with rsp_ready_i=4'b0100 → rsp_valid_o=4'b0100, rsp_data_o=0xCAFE, slv_rsp_ready_o=1, outstanding_o returns to 0.
- In-order routing: push idx 3, 0, 1. Three responses D0, D1, D2 in consecutive cycles → rsp_valid_o = 4'b1000, 4'b0001, 4'b0010 with D0, D1, D2 in order.
- Full back-pressure: MaxOutstanding=4, 4 requests accepted → slv_req_o=0 and arb_gnt_o=0 with arb_req_i=1. Same-cycle pop and request → no push; outstanding_o=3 next cycle, then the request is accepted.
- Head stall: head idx=1 with rsp_ready_i[1]=0 and rsp_ready_i[0]=1 → slv_rsp_ready_o=0 and no pop. Raise rsp_ready_i[1] → pop.
- Pointer wrap: MaxOutstanding=3, 7 interleaved push/pop pairs → every response goes to the correct index; outstanding_o never exceeds 3.
- Error and flush: response while empty → slv_rsp_ready_o=0; err_o=1 next cycle with ARB_RESP_DEMUX_ERR_EN, 0 without. flush_i with 2 entries → outstanding_o=0 next cycle, err_o unchanged.
